// File: rtl/sprite_motion_sched.sv
// rtl/sprite_motion_sched.sv - time-multiplexed bouncing-sprite motion scheduler
// One shared step/bounce datapath walks all sprites per frame; displayed positions swap atomically.
module sprite_motion_sched #(
  parameter int NUM_SPRITES = 4,
  parameter int SIZE        = 20,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int CW          = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic                      pause,
  input  logic [1:0]                speed,
  output logic [CW*NUM_SPRITES-1:0] pos_x,
  output logic [CW*NUM_SPRITES-1:0] pos_y,
  output logic                      busy,
  output logic                      done,
  output logic                      bounce,
  output logic [2:0]                bounce_id,
  output logic                      overrun
);

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IW-1:0] LAST   = IW'(NUM_SPRITES - 1);
  localparam logic [CW:0]   LO     = (CW+1)'(SIZE);
  localparam logic [CW:0]   X_HI   = (CW+1)'(H_RES - SIZE);
  localparam logic [CW:0]   Y_HI   = (CW+1)'(V_RES - SIZE);
  localparam logic [CW-1:0] LO_C   = CW'(SIZE);
  localparam logic [CW-1:0] X_HI_C = CW'(H_RES - SIZE);
  localparam logic [CW-1:0] Y_HI_C = CW'(V_RES - SIZE);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT, COPY} state_t;
  state_t state_q, state_d;

  logic [IW-1:0] idx_q;
  logic [2:0]    step_q;
  logic [CW-1:0] wx_q [NUM_SPRITES];
  logic [CW-1:0] wy_q [NUM_SPRITES];
  logic          wdx_q [NUM_SPRITES];  // 1 = moving right
  logic          wdy_q [NUM_SPRITES];  // 1 = moving down
  logic [CW-1:0] dx_q [NUM_SPRITES];
  logic [CW-1:0] dy_q [NUM_SPRITES];
  logic [CW-1:0] cx_q, cy_q;
  logic          cdx_q, cdy_q, cb_q;
  logic          done_q, bounce_q, overrun_q;
  logic [2:0]    bid_q;

  logic [CW:0]   ex, ey, stp, sx, sy;
  logic [CW-1:0] nx, ny;
  logic          ndx, ndy, bx, by;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start && !pause) state_d = CALC;
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = (idx_q == LAST) ? COPY : CALC;
      COPY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Step and clamp one sprite; compares are CW+1 bits wide so nothing wraps.
  always_comb begin
    ex  = {1'b0, wx_q[idx_q]};
    ey  = {1'b0, wy_q[idx_q]};
    stp = (CW+1)'(step_q);
    sx  = ex + stp;
    sy  = ey + stp;
    nx  = wx_q[idx_q];
    ny  = wy_q[idx_q];
    ndx = wdx_q[idx_q];
    ndy = wdy_q[idx_q];
    bx  = 1'b0;
    by  = 1'b0;
    if (wdx_q[idx_q]) begin
      if (sx >= X_HI) begin nx = X_HI_C; ndx = 1'b0; bx = 1'b1; end
      else            nx = wx_q[idx_q] + CW'(step_q);
    end else begin
      if (ex <= LO + stp) begin nx = LO_C; ndx = 1'b1; bx = 1'b1; end
      else                nx = wx_q[idx_q] - CW'(step_q);
    end
    if (wdy_q[idx_q]) begin
      if (sy >= Y_HI) begin ny = Y_HI_C; ndy = 1'b0; by = 1'b1; end
      else            ny = wy_q[idx_q] + CW'(step_q);
    end else begin
      if (ey <= LO + stp) begin ny = LO_C; ndy = 1'b1; by = 1'b1; end
      else                ny = wy_q[idx_q] - CW'(step_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      step_q    <= 3'd1;
      cx_q      <= '0;
      cy_q      <= '0;
      cdx_q     <= 1'b0;
      cdy_q     <= 1'b0;
      cb_q      <= 1'b0;
      done_q    <= 1'b0;
      bounce_q  <= 1'b0;
      bid_q     <= 3'd0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        wx_q[i]  <= CW'(SIZE + 64 * (i + 1));
        wy_q[i]  <= CW'(SIZE + 48 * (i + 1));
        dx_q[i]  <= CW'(SIZE + 64 * (i + 1));
        dy_q[i]  <= CW'(SIZE + 48 * (i + 1));
        wdx_q[i] <= ((i % 2) == 0);
        wdy_q[i] <= 1'b1;
      end
    end else begin
      done_q   <= 1'b0;
      bounce_q <= 1'b0;
      bid_q    <= 3'd0;
      if (frame_start && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (frame_start && !pause) begin
          idx_q  <= '0;
          step_q <= {1'b0, speed} + 3'd1;
        end
        CALC: begin
          cx_q  <= nx;
          cy_q  <= ny;
          cdx_q <= ndx;
          cdy_q <= ndy;
          cb_q  <= bx | by;
        end
        COMMIT: begin
          wx_q[idx_q]  <= cx_q;
          wy_q[idx_q]  <= cy_q;
          wdx_q[idx_q] <= cdx_q;
          wdy_q[idx_q] <= cdy_q;
          if (cb_q) begin
            bounce_q <= 1'b1;
            bid_q    <= 3'(idx_q);
          end
          if (idx_q != LAST) idx_q <= idx_q + 1'b1;
        end
        COPY: begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            dx_q[i] <= wx_q[i];
            dy_q[i] <= wy_q[i];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign pos_x[CW*g +: CW] = dx_q[g];
    assign pos_y[CW*g +: CW] = dy_q[g];
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign bounce    = bounce_q;
  assign bounce_id = bid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_motion_sched.sv
// tb/tb_sprite_motion_sched.sv - directed self-checking bench for sprite_motion_sched
// Cycle-accurate burst timing, clamping/bounce frames, overrun, pause and async reset.
module tb_sprite_motion_sched;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, pause;
  logic [1:0]  speed;
  logic [39:0] pos_x, pos_y;
  logic        busy, done, bounce, overrun;
  logic [2:0]  bounce_id;

  int checks = 0;
  int failures = 0;

  localparam logic [39:0] RST_X = {10'd276, 10'd212, 10'd148, 10'd84};
  localparam logic [39:0] RST_Y = {10'd212, 10'd164, 10'd116, 10'd68};

  sprite_motion_sched dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pause(pause), .speed(speed),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .bounce(bounce),
    .bounce_id(bounce_id), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt, act_cnt;
    logic [39:0] px, py;
    logic b0, b1;
    logic [2:0] id0, id1, id4;
    int ex, ey;

    rst_n = 1'b0; frame_start = 1'b0; pause = 1'b0; speed = 2'd0;
    tick(); tick();
    check("rst_pos_x", pos_x, RST_X);
    check("rst_pos_y", pos_y, RST_Y);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick(); tick();

    // single burst at speed 0 with cycle-exact busy/done
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    done_cnt = 0; act_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      if (busy !== 1'b1) act_cnt++;
      if (done !== 1'b0 || bounce !== 1'b0) done_cnt++;
      if (pos_x !== RST_X) done_cnt++;
      tick();
    end
    check("f1_busy_window", act_cnt, 0);
    check("f1_early_done", done_cnt, 0);
    check("f1_done_t10", done, 1);
    check("f1_busy_t10", busy, 0);
    check("f1_s0_x", pos_x[9:0], 85);
    check("f1_s0_y", pos_y[9:0], 69);
    check("f1_s1_x", pos_x[19:10], 147);
    check("f1_s1_y", pos_y[19:10], 117);
    tick();
    check("f1_done_pulse", done, 0);

    // overrun: second frame_start at T+3
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    done_cnt = (done === 1'b1) ? 1 : 0;
    tick(); tick();
    check("ovr_before", overrun, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("ovr_set_t4", overrun, 1);
    for (int c = 4; c < 14; c++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    check("ovr_single_done", done_cnt, 1);
    check("ovr_sticky", overrun, 1);
    check("ovr_s0_x", pos_x[9:0], 86);

    // pause blocks burst start
    pause = 1'b1; px = pos_x; py = pos_y;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    act_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy === 1'b1 || done === 1'b1) act_cnt++;
      tick();
    end
    check("pause_no_activity", act_cnt, 0);
    check("pause_pos_x", pos_x, px);
    check("pause_pos_y", pos_y, py);
    pause = 1'b0; tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (9) tick();
    check("unpause_done", done, 1);
    check("unpause_s0_x", pos_x[9:0], 87);
    check("unpause_s0_y", pos_y[9:0], 71);
    check("unpause_s1_x", pos_x[19:10], 145);
    check("unpause_s1_y", pos_y[19:10], 119);
    tick();

    // asynchronous reset mid-burst at T+5
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (4) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_pos_x", pos_x, RST_X);
    check("arst_pos_y", pos_y, RST_Y);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // speed=3 frames from reset; speed drops to 0 after latch each frame
    for (int f = 1; f <= 134; f++) begin
      speed = 2'd3;
      frame_start = 1'b1; tick(); frame_start = 1'b0; speed = 2'd0;
      b0 = 1'b0; b1 = 1'b0; id0 = 3'd0; id1 = 3'd0; id4 = 3'd0;
      for (int c = 1; c <= 10; c++) begin
        if (c == 3) begin b0 = bounce; id0 = bounce_id; end
        if (c == 4) id4 = bounce_id;
        if (c == 5) begin b1 = bounce; id1 = bounce_id; end
        if (c < 10) tick();
      end
      ex = (f < 134) ? 84 + 4 * f : 620;
      ey = (f <= 98) ? 68 + 4 * f : 460 - 4 * (f - 98);
      check($sformatf("run_done_f%0d", f), done, 1);
      check($sformatf("run_s0_x_f%0d", f), pos_x[9:0], ex);
      check($sformatf("run_s0_y_f%0d", f), pos_y[9:0], ey);
      check($sformatf("run_b0_f%0d", f), b0, (f == 98 || f == 134));
      check($sformatf("run_b1_f%0d", f), b1, (f == 32 || f == 86));
      if (b0) check($sformatf("run_id0_f%0d", f), id0, 0);
      if (b1) check($sformatf("run_id1_f%0d", f), id1, 1);
      if (f == 98) check("run_id_idle_f98", id4, 0);
      repeat (10) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_motion_sched.md
Name: sprite_motion_sched

Overview:
- Time-multiplexed motion controller for up to 8 bouncing sprites (balls) on the 640x480 VGA scene.
- Shares one step/boundary-check datapath across all sprites. Each frame it walks through every sprite during a short burst after the frame-start tick.
- Working positions are double-buffered. The downstream circle/shadow renderer sees all sprites update atomically, once per frame.

Parameters:
- NUM_SPRITES, 4, number of sprites; legal range 1..8.
- SIZE, 20, sprite radius in pixels; sets the bounce margin.
- H_RES, 640, active width in pixels.
- V_RES, 480, active height in pixels.
- CW, 10, coordinate width in bits.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_start  in  1  one-cycle pulse at hpos==0 && vpos==0
- pause  in  1  1 = ignore frame_start; positions freeze
- speed  in  2  step size per frame = speed+1 pixels (1..4), applied to both axes
- pos_x  out  CW*NUM_SPRITES  displayed x centres, packed; sprite i at [CW*i +: CW]
- pos_y  out  CW*NUM_SPRITES  displayed y centres, packed likewise
- busy  out  1  high while an update burst is in progress
- done  out  1  one-cycle pulse when pos_x/pos_y take new values
- bounce  out  1  one-cycle pulse when a sprite hits any edge
- bounce_id  out  3  index of the bouncing sprite; valid when bounce=1, otherwise 0
- overrun  out  1  sticky; set when frame_start arrives while busy

Behaviour:
- Reset (async, immediate, including mid-burst):
  - FSM returns to IDLE; busy, done, bounce, bounce_id, overrun = 0.
  - Working and displayed x_i = SIZE+64*(i+1); y_i = SIZE+48*(i+1).
  - dir_x_i = right for even i, left for odd i; dir_y_i = down for all i.
- FSM states IDLE -> CALC -> COMMIT -> (CALC for next idx | COPY) -> IDLE.
  - IDLE: frame_start && !pause -> CALC with idx=0. frame_start && pause -> stay in IDLE; nothing changes.
  - CALC: register new x/y/dir for sprite idx from the working registers and the step latched from speed in the IDLE->CALC cycle. speed changes mid-burst have no effect.
  - COMMIT: write working registers for sprite idx; pulse bounce if either axis bounced (one pulse even if both axes bounce); bounce_id=idx. idx==NUM_SPRITES-1 -> COPY, else idx+1 -> CALC.
  - COPY: all displayed registers <= working registers in a single cycle -> IDLE.
- Timing, for frame_start sampled high in cycle T:
  - busy=1 for cycles T+1 .. T+1+2N (N = NUM_SPRITES).
  - pos_x/pos_y and done=1 take new values at T+2+2N.
  - Sprite k's bounce pulse is at T+3+2k.
- Axis arithmetic, x shown; y is identical with V_RES. All compares use unsigned CW+1 bits, with no wrap.
  - Moving right: if x+step >= H_RES-SIZE then x=H_RES-SIZE, dir=left, bounce; else x=x+step.
  - Moving left: if x <= SIZE+step then x=SIZE, dir=right, bounce; else x=x-step.
  - Positions never leave [SIZE, RES-SIZE].
- frame_start while busy: ignored and overrun set to 1. overrun clears only on reset.
- pause only gates burst start. A burst already running completes.
- Displayed outputs change only in COPY; they are stable for all other cycles.

Test Plan:
- Reset, N=4:
  - pos_x = {276,212,148,84} (sprite 3..0).
  - pos_y = {212,164,116,68}.
  - busy=0, overrun=0.
- One frame_start at T with speed=0:
  - busy high T+1..T+9; done and new outputs at T+10.
  - Sprite 0 = (85,69); sprite 1 = (147,117).
  - No bounce pulse.
- speed=3, one frame_start every 1000 cycles:
  - Frame 98: bounce with bounce_id=0; sprite 0 y=460, moving up.
  - Frame 134: bounce with bounce_id=0; sprite 0 x=620, moving left.
  - Between bounces, values increase by exactly 4 per frame.
- frame_start at T and T+3: overrun=1 from T+4 and stays 1; single done at T+10.
- pause=1 with frame_start: no busy, no done, outputs unchanged. Release pause; the next frame_start updates normally.
- rst_n low at T+5 mid-burst: outputs return to reset values within the same cycle without a clock edge; busy=0. After release, a new burst completes correctly.
